buffer_edge_counter: RTL and testbench
======================================

// Module: buffer_edge_counter
// PURPOSE
//  Downstream consumer of the single-bit buffer stage output.
//  Synchronises the buffered level to clk, debounces it, and emits one-cycle rise/fall pulses.
//  Keeps a saturating count of debounced rising edges for the testbench/status logic.
// PARAMETERS
//  STABLE_CYCLES  4  consecutive synced samples differing from level before level toggles (>=1)
//  CNT_W          8  width of edge counter(s) (>=2)
// PORTS
//  clk         in   1      single clock, rising-edge
//  rst_n       in   1      synchronous, active-low reset
//  s_in        in   1      buffered level from buffer stage (async to clk)
//  clr         in   1      synchronous clear of counters and sat
//  level       out  1      debounced level
//  rise_pulse  out  1      1-cycle pulse when level goes 0->1
//  fall_pulse  out  1      1-cycle pulse when level goes 1->0
//  rise_count  out  CNT_W  saturating count of rise_pulse
//  sat         out  1      high while rise_count == all-ones
//  fall_count  out  CNT_W  only with FALL_COUNT_EN
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): sync flops=0, state=IDLE_LOW, stab_cnt=0, level=0, pulses=0,
//   counters=0, sat=0. Reset mid-debounce discards the pending change.
//  Sync: 2-flop chain s_in -> ff1 -> sync_q; FSM sees only sync_q.
//  FSM states: IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW (level=1 in IDLE_HIGH/WAIT_LOW).
//   IDLE_x: sync_q != level -> WAIT_y, stab_cnt=1 (if STABLE_CYCLES==1, toggle directly).
//   WAIT_y: sync_q == level -> back to IDLE_x, stab_cnt=0 (glitch rejected).
//           sync_q != level, stab_cnt==STABLE_CYCLES-1 -> IDLE_y, level toggles, pulse=1.
//           else stab_cnt++.
//  Latency: level/pulse change at the (STABLE_CYCLES+2)-th posedge, counting the posedge
//   that first samples new s_in as edge 1 (default: edge 6).
//  Pulses are registered, high exactly one cycle; rise and fall never high together.
//  rise_count: +1 on rise_pulse cycle; holds at 2^CNT_W-1 (no wrap); sat = (rise_count==max).
//  clr: counters->0, sat->0 next edge; level/FSM unaffected.
//   clr with simultaneous rise_pulse -> rise_count=1 (clear, then count).
//  stab_cnt width $clog2(STABLE_CYCLES+1); no arithmetic exceeds it.
// CONFIGURATION
//  FALL_COUNT_EN defined: fall_count port present, same saturate/clr rules driven by fall_pulse.
//  Not defined: fall_count port and logic absent; fall_pulse still generated.
// STRUCTURE
//  Package buffer_pkg: typedef enum logic [1:0] dbnc_state_t {IDLE_LOW, WAIT_HIGH, IDLE_HIGH,
//   WAIT_LOW}; localparam SYNC_STAGES=2.
//  Sub-module sync2 (clk, rst_n, d, q): 2-flop synchroniser, reset to 0.
//  Top: sync2 + FSM/stab_cnt + counter block (generate-free; macro-gated fall counter).
// TESTING
//  Reset: hold rst_n=0 3 cycles with s_in=1 -> level=0, rise_count=0, pulses 0; release -> rise after edge 6.
//  Clean rise: s_in 0->1 held 10 cycles -> level=1 at edge 6, rise_pulse 1 cycle, rise_count=1.
//  Glitch: s_in high 3 cycles then low -> level stays 0, no pulse, rise_count unchanged.
//  Saturation: CNT_W=2, 5 clean rise/fall cycles -> rise_count 1,2,3,3,3; sat=1 from 3rd rise.
//  clr same cycle as rise_pulse (count=2) -> rise_count=1, sat=0; clr alone -> 0.
//  Reset mid-WAIT_HIGH (stab_cnt=2) -> level=0, state IDLE_LOW; with FALL_COUNT_EN, fall_count=0.

Source files
------------

// File: rtl/buffer_pkg.sv
// Shared types and constants for the buffered-level debouncer and edge counter.
package buffer_pkg;

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    WAIT_LOW  = 2'd3
  } dbnc_state_t;

  localparam int unsigned SYNC_STAGES = 2;

endpackage

// File: rtl/buffer_edge_counter_sync2.sv
// Two-flop synchroniser for a single asynchronous level; synchronous active-low reset to 0.
module sync2
  import buffer_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] chain_q;
  logic [SYNC_STAGES-1:0] chain_d;

  always_comb begin
    chain_d = {chain_q[SYNC_STAGES-2:0], d};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chain_q <= '0;
    end else begin
      chain_q <= chain_d;
    end
  end

  assign q = chain_q[SYNC_STAGES-1];

endmodule

// File: rtl/buffer_edge_counter.sv
// Synchronise, debounce and edge-detect a buffered level; saturating rise counter.
// Optional fall counter enabled by defining FALL_COUNT_EN.
module buffer_edge_counter
  import buffer_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_in,
  input  logic             clr,
  output logic             level,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] rise_count,
  output logic             sat
`ifdef FALL_COUNT_EN
  ,
  output logic [CNT_W-1:0] fall_count
`endif
);

  localparam int unsigned      STAB_W  = $clog2(STABLE_CYCLES + 1);
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;

  logic sync_q;

  sync2 u_sync2 (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (s_in),
    .q     (sync_q)
  );

  dbnc_state_t       state_q, state_d;
  logic [STAB_W-1:0] stab_cnt_q, stab_cnt_d;
  logic              level_q, level_d;
  logic              rise_pulse_q, rise_pulse_d;
  logic              fall_pulse_q, fall_pulse_d;
  logic [CNT_W-1:0]  rise_count_q, rise_count_d;
  logic              sat_q, sat_d;

  // Debounce FSM: a change must persist STABLE_CYCLES synced samples to be accepted.
  always_comb begin
    state_d      = state_q;
    stab_cnt_d   = stab_cnt_q;
    rise_pulse_d = 1'b0;
    fall_pulse_d = 1'b0;
    unique case (state_q)
      IDLE_LOW: begin
        if (sync_q) begin
          if (STABLE_CYCLES == 1) begin
            state_d      = IDLE_HIGH;
            rise_pulse_d = 1'b1;
          end else begin
            state_d    = WAIT_HIGH;
            stab_cnt_d = STAB_W'(1);
          end
        end
      end
      WAIT_HIGH: begin
        if (!sync_q) begin
          state_d    = IDLE_LOW;
          stab_cnt_d = '0;
        end else if (stab_cnt_q == STAB_LAST) begin
          state_d      = IDLE_HIGH;
          stab_cnt_d   = '0;
          rise_pulse_d = 1'b1;
        end else begin
          stab_cnt_d = stab_cnt_q + STAB_W'(1);
        end
      end
      IDLE_HIGH: begin
        if (!sync_q) begin
          if (STABLE_CYCLES == 1) begin
            state_d      = IDLE_LOW;
            fall_pulse_d = 1'b1;
          end else begin
            state_d    = WAIT_LOW;
            stab_cnt_d = STAB_W'(1);
          end
        end
      end
      WAIT_LOW: begin
        if (sync_q) begin
          state_d    = IDLE_HIGH;
          stab_cnt_d = '0;
        end else if (stab_cnt_q == STAB_LAST) begin
          state_d      = IDLE_LOW;
          stab_cnt_d   = '0;
          fall_pulse_d = 1'b1;
        end else begin
          stab_cnt_d = stab_cnt_q + STAB_W'(1);
        end
      end
      default: begin
        state_d    = IDLE_LOW;
        stab_cnt_d = '0;
      end
    endcase
    level_d = (state_d == IDLE_HIGH) || (state_d == WAIT_LOW);
  end

  // Clear first, then count the pulse of the current cycle, holding at max.
  always_comb begin
    rise_count_d = clr ? '0 : rise_count_q;
    if (rise_pulse_q && (rise_count_d != CNT_MAX)) begin
      rise_count_d = rise_count_d + CNT_W'(1);
    end
    sat_d = (rise_count_d == CNT_MAX);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE_LOW;
      stab_cnt_q   <= '0;
      level_q      <= 1'b0;
      rise_pulse_q <= 1'b0;
      fall_pulse_q <= 1'b0;
      rise_count_q <= '0;
      sat_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      stab_cnt_q   <= stab_cnt_d;
      level_q      <= level_d;
      rise_pulse_q <= rise_pulse_d;
      fall_pulse_q <= fall_pulse_d;
      rise_count_q <= rise_count_d;
      sat_q        <= sat_d;
    end
  end

  assign level      = level_q;
  assign rise_pulse = rise_pulse_q;
  assign fall_pulse = fall_pulse_q;
  assign rise_count = rise_count_q;
  assign sat        = sat_q;

`ifdef FALL_COUNT_EN
  logic [CNT_W-1:0] fall_count_q, fall_count_d;

  always_comb begin
    fall_count_d = clr ? '0 : fall_count_q;
    if (fall_pulse_q && (fall_count_d != CNT_MAX)) begin
      fall_count_d = fall_count_d + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fall_count_q <= '0;
    end else begin
      fall_count_q <= fall_count_d;
    end
  end

  assign fall_count = fall_count_q;
`endif

endmodule

// File: tb/tb_buffer_edge_counter.sv
// Self-checking bench for buffer_edge_counter: vector table, corner sequences, random vs model.
module tb_buffer_edge_counter;

  localparam int STABLE = 4;
  localparam int CNT_W  = 2;
  localparam int MAXC   = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n, s_in, clr;
  logic             level, rise_pulse, fall_pulse, sat;
  logic [CNT_W-1:0] rise_count;
`ifdef FALL_COUNT_EN
  logic [CNT_W-1:0] fall_count;
`endif

  buffer_edge_counter #(.STABLE_CYCLES(STABLE), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_in       (s_in),
    .clr        (clr),
    .level      (level),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .rise_count (rise_count),
    .sat        (sat)
`ifdef FALL_COUNT_EN
    ,
    .fall_count (fall_count)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: synced value is the sample taken two edges earlier; level flips
  // once the synced value has disagreed with it on STABLE consecutive edges.
  bit m_hist[$];
  int m_run, m_rc, m_fc;
  bit m_lvl, m_rp, m_fp;

  task automatic model_edge();
    bit sy;
    if (!rst_n) begin
      m_hist = '{1'b0, 1'b0};
      m_run = 0; m_lvl = 0; m_rp = 0; m_fp = 0; m_rc = 0; m_fc = 0;
    end else begin
      sy = m_hist.pop_front();
      m_hist.push_back(s_in);
      if (clr) begin m_rc = 0; m_fc = 0; end
      if (m_rp && m_rc < MAXC) m_rc++;
      if (m_fp && m_fc < MAXC) m_fc++;
      m_rp = 0; m_fp = 0;
      m_run = (sy != m_lvl) ? m_run + 1 : 0;
      if (m_run == STABLE) begin
        m_lvl = !m_lvl; m_rp = m_lvl; m_fp = !m_lvl; m_run = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".level"}, int'(level), int'(m_lvl));
    chk({tag, ".rise_pulse"}, int'(rise_pulse), int'(m_rp));
    chk({tag, ".fall_pulse"}, int'(fall_pulse), int'(m_fp));
    chk({tag, ".rise_count"}, int'(rise_count), m_rc);
    chk({tag, ".sat"}, int'(sat), int'(m_rc == MAXC));
`ifdef FALL_COUNT_EN
    chk({tag, ".fall_count"}, int'(fall_count), m_fc);
`endif
  endtask

  typedef struct {
    bit rst_n, s_in, clr;
    bit lvl, rp, fp;
    int cnt;
    bit st;
  } vec_t;

  vec_t vt[$];

  task automatic add(bit r, bit s, bit c, bit l, bit rp, bit fp, int cnt);
    vec_t v;
    v = '{rst_n: r, s_in: s, clr: c, lvl: l, rp: rp, fp: fp, cnt: cnt, st: (cnt == MAXC)};
    vt.push_back(v);
  endtask

  task automatic clean_level(bit v, int cycles);
    s_in = v;
    for (int i = 0; i < cycles; i++) begin
      tick();
      chk_model("seq");
    end
  endtask

  initial begin
    rst_n = 1'b0; s_in = 1'b1; clr = 1'b0;

    // Reset with s_in high, clean rise at edge 6, clean fall, then a 3-cycle glitch.
    for (int i = 0; i < 3; i++) add(0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) add(1, 1, 0, 0, 0, 0, 0);
    add(1, 1, 0, 1, 1, 0, 0);
    for (int i = 0; i < 4; i++) add(1, 1, 0, 1, 0, 0, 1);
    for (int i = 0; i < 5; i++) add(1, 0, 0, 1, 0, 0, 1);
    add(1, 0, 0, 0, 0, 1, 1);
    add(1, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) add(1, 1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 7; i++) add(1, 0, 0, 0, 0, 0, 1);

    foreach (vt[i]) begin
      rst_n = vt[i].rst_n; s_in = vt[i].s_in; clr = vt[i].clr;
      tick();
      chk($sformatf("vec%0d.level", i), int'(level), int'(vt[i].lvl));
      chk($sformatf("vec%0d.rise_pulse", i), int'(rise_pulse), int'(vt[i].rp));
      chk($sformatf("vec%0d.fall_pulse", i), int'(fall_pulse), int'(vt[i].fp));
      chk($sformatf("vec%0d.rise_count", i), int'(rise_count), vt[i].cnt);
      chk($sformatf("vec%0d.sat", i), int'(sat), int'(vt[i].st));
    end

    // Saturation: from a clear, five clean rises give 1,2,3,3,3.
    clr = 1'b1; tick(); clr = 1'b0;
    chk("clr_before_sat.rise_count", int'(rise_count), 0);
    for (int k = 1; k <= 5; k++) begin
      clean_level(1'b1, 8);
      chk($sformatf("sat_rise%0d.rise_count", k), int'(rise_count), (k < MAXC) ? k : MAXC);
      chk($sformatf("sat_rise%0d.sat", k), int'(sat), int'(k >= MAXC));
      clean_level(1'b0, 8);
    end

    // clr coincident with rise_pulse while count is 2: clear then count gives 1.
    clr = 1'b1; tick(); clr = 1'b0;
    clean_level(1'b1, 8);
    clean_level(1'b0, 8);
    clean_level(1'b1, 8);
    clean_level(1'b0, 8);
    chk("pre_clr_rise.rise_count", int'(rise_count), 2);
    s_in = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    chk("pre_clr_rise.rise_pulse", int'(rise_pulse), 1);
    clr = 1'b1; tick(); clr = 1'b0;
    chk("clr_with_rise.rise_count", int'(rise_count), 1);
    chk("clr_with_rise.sat", int'(sat), 0);
    chk("clr_with_rise.level", int'(level), 1);
    clr = 1'b1; tick(); clr = 1'b0;
    chk("clr_alone.rise_count", int'(rise_count), 0);
    chk("clr_alone.level", int'(level), 1);

    // Reset while in WAIT_HIGH discards the pending rise.
    clean_level(1'b0, 10);
    clean_level(1'b1, 4);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    chk("mid_rst.level", int'(level), 0);
    chk("mid_rst.rise_pulse", int'(rise_pulse), 0);
    chk("mid_rst.rise_count", int'(rise_count), 0);
`ifdef FALL_COUNT_EN
    chk("mid_rst.fall_count", int'(fall_count), 0);
`endif
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("post_rst%0d.level", i + 1), int'(level), 0);
    end
    tick();
    chk("post_rst6.level", int'(level), 1);
    chk("post_rst6.rise_pulse", int'(rise_pulse), 1);

    // Randomised stimulus with sticky levels so both glitches and clean edges occur.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(5) == 0) s_in = ~s_in;
      clr   = ($urandom_range(39) == 0);
      rst_n = ($urandom_range(399) != 0);
      tick();
      chk_model("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
